pc_fetch: RTL and testbench

Program-counter and next-PC stage for the single-cycle MIPS datapath. Sits directly upstream of the 4 KB instruction memory and drives its word address from the current PC. Each cycle it computes the next PC from the sequential, branch, jump or jump-register source, and advances when not stalled. A small control FSM handles boot, halt and misaligned-target fault, and a retired-instruction counter is kept.

---
 rtl/pc_fetch.sv | 151 +++++++++++++++
 tb/tb_pc_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//
// Program-counter and next-PC stage for the single-cycle MIPS datapath.
// The current PC drives the word address of the 4 KB instruction memory.
// Each cycle the next PC is chosen from one of four sources:
//   - the sequential address,
//   - the branch target,
//   - the jump target,
//   - the jump-register target.
// The PC advances to that next PC unless the stage is stalled.
//
// A small control FSM sequences the stage:
//   BOOT  -> RUN              one cycle after reset is released.
//   RUN   -> HALT             on a halt request.
//   RUN   -> FAULT            on a misaligned jump-register target.
//   HALT, FAULT               sticky until reset.
//
// The stage also keeps a count of retired instructions.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   stall         hold PC/count/state this cycle (masks halt and fault)
//   npc_op        00 seq, 01 branch, 10 jump (j/jal), 11 jr
//   branch_taken  branch condition, used only when npc_op = 01
//   imm16         branch offset in words (sign-extended)
//   imm26         jump target field
//   rs_data       jr target address
//   halt_req      current instruction is a halt/syscall
//   pc            current PC
//   pc_plus4      pc + 4 (jal link value), combinational
//   im_addr       pc[11:2], instruction-memory word address, combinational
//   fetch_valid   current instruction is valid to execute (RUN only)
//   halted        FSM is in HALT
//   misaligned    FSM is in FAULT
//   instr_count   retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module pc_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [1:0]         npc_op,
    input  logic               branch_taken,
    input  logic [15:0]        imm16,
    input  logic [25:0]        imm26,
    input  logic [31:0]        rs_data,
    input  logic               halt_req,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic [9:0]         im_addr,
    output logic               fetch_valid,
    output logic               halted,
    output logic               misaligned,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t      state;
    logic [31:0] npc;
    logic [31:0] branch_off;

    // Sequential address and instruction-memory word address follow pc directly.
    assign pc_plus4 = pc + 32'd4;
    assign im_addr  = pc[11:2];

    // Branch offset is a word count; sign-extend it and scale it to bytes.
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

    // Next-PC source selection.
    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            2'b00: npc = pc_plus4;
            2'b01: begin
                if (branch_taken) begin
                    npc = pc_plus4 + branch_off;
                end else begin
                    npc = pc_plus4;
                end
            end
            2'b10: npc = {pc_plus4[31:28], imm26, 2'b00};
            2'b11: npc = rs_data;
            default: npc = pc_plus4;
        endcase
    end

    // Control FSM with PC register, retired-instruction counter and
    // registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_BOOT;
            pc          <= PC_RESET;
            instr_count <= '0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    // The PC already holds PC_RESET; just open the fetch window.
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (stall) begin
                        // Stall freezes everything and masks halt/fault.
                        state <= ST_RUN;
                    end else if (halt_req) begin
                        // The halt instruction itself retires; PC stays on it.
                        instr_count <= instr_count + COUNT_W'(1);
                        state       <= ST_HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else if (npc[1:0] != 2'b00) begin
                        // Only jr can produce this. Keep the offending jr's PC
                        // for debug, and do not retire it.
                        state       <= ST_FAULT;
                        fetch_valid <= 1'b0;
                        misaligned  <= 1'b1;
                    end else begin
                        pc          <= npc;
                        instr_count <= instr_count + COUNT_W'(1);
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state       <= ST_FAULT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                    misaligned  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

    localparam logic [31:0] PC_RST = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  npc_op;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_data;
    logic        halt_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [9:0]  im_addr;
    logic        fetch_valid;
    logic        halted;
    logic        misaligned;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state: 0 boot, 1 run, 2 halt, 3 fault
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    int          m_st;

    pc_fetch #(.PC_RESET(PC_RST), .COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op),
        .branch_taken(branch_taken), .imm16(imm16), .imm26(imm26),
        .rs_data(rs_data), .halt_req(halt_req), .pc(pc), .pc_plus4(pc_plus4),
        .im_addr(im_addr), .fetch_valid(fetch_valid), .halted(halted),
        .misaligned(misaligned), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task idle_inputs();
        stall = 1'b0; npc_op = 2'b00; branch_taken = 1'b0; imm16 = 16'h0;
        imm26 = 26'h0; rs_data = 32'h0; halt_req = 1'b0;
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; pulses reset fully between clock edges.
    task do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        m_pc = PC_RST; m_cnt = 32'd0; m_st = 0;
    endtask

    task goto_addr(input logic [31:0] a);
        npc_op = 2'b11; rs_data = a;
        tick();
        npc_op = 2'b00;
    endtask

    // Behavioural next-state from the architectural rules.
    task model_step();
        logic [31:0] seq;
        logic [31:0] tgt;
        int          off;
        seq = m_pc + 32'd4;
        off = $signed(imm16);
        case (npc_op)
            2'd0: tgt = seq;
            2'd1: tgt = branch_taken ? seq + 32'(off * 4) : seq;
            2'd2: tgt = (seq & 32'hF000_0000) | (32'(imm26) << 2);
            default: tgt = rs_data;
        endcase
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1 && !stall) begin
            if (halt_req) begin
                m_cnt = m_cnt + 32'd1;
                m_st  = 2;
            end else if (tgt % 4 != 0) begin
                m_st = 3;
            end else begin
                m_pc  = tgt;
                m_cnt = m_cnt + 32'd1;
            end
        end
    endtask

    task test_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        checks++;
        if (pc !== PC_RST || instr_count !== 32'd0 || fetch_valid !== 1'b0 ||
            halted !== 1'b0 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pc=%h cnt=%0d fv=%b h=%b m=%b want pc=%h cnt=0 fv=0 h=0 m=0",
                     pc, instr_count, fetch_valid, halted, misaligned, PC_RST);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (fetch_valid !== 1'b0 || pc !== PC_RST) begin
            failures++;
            $display("FAIL boot_cycle: fv=%b pc=%h want fv=0 pc=%h", fetch_valid, pc, PC_RST);
        end
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || pc !== PC_RST || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL boot_to_run: fv=%b pc=%h cnt=%0d want fv=1 pc=%h cnt=0",
                     fetch_valid, pc, instr_count, PC_RST);
        end
        repeat (3) tick();
        checks++;
        if (pc !== 32'h300C || instr_count !== 32'd3 || pc_plus4 !== 32'h3010 || im_addr !== 10'h003) begin
            failures++;
            $display("FAIL seq3: pc=%h cnt=%0d p4=%h ia=%h want pc=300c cnt=3 p4=3010 ia=003",
                     pc, instr_count, pc_plus4, im_addr);
        end
    endtask

    task test_branch();
        do_reset(); tick();
        goto_addr(32'h3010);
        npc_op = 2'b01; imm16 = 16'hFFFC; branch_taken = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h3004 || instr_count !== 32'd2) begin
            failures++;
            $display("FAIL branch_back: pc=%h cnt=%0d want pc=3004 cnt=2", pc, instr_count);
        end
        goto_addr(32'h3010);
        npc_op = 2'b01; imm16 = 16'hFFFC; branch_taken = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h3014) begin
            failures++;
            $display("FAIL branch_not_taken: pc=%h want 3014", pc);
        end
        goto_addr(32'h3010);
        npc_op = 2'b01; imm16 = 16'h0003; branch_taken = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h3020) begin
            failures++;
            $display("FAIL branch_fwd: pc=%h want 3020", pc);
        end
        idle_inputs();
    endtask

    task test_jump();
        do_reset(); tick();
        goto_addr(32'h3008);
        npc_op = 2'b10; imm26 = 26'h0000C10;
        tick();
        checks++;
        if (pc !== 32'h0000_3040) begin
            failures++;
            $display("FAIL jump: pc=%h want 00003040", pc);
        end
        npc_op = 2'b11; rs_data = 32'h3100;
        tick();
        checks++;
        if (pc !== 32'h3100) begin
            failures++;
            $display("FAIL jr: pc=%h want 3100", pc);
        end
        goto_addr(32'h3008);
        npc_op = 2'b11; rs_data = 32'h3102;
        tick();
        checks++;
        if (misaligned !== 1'b1 || pc !== 32'h3008 || fetch_valid !== 1'b0 || instr_count !== 32'd4) begin
            failures++;
            $display("FAIL jr_fault: m=%b pc=%h fv=%b cnt=%0d want m=1 pc=3008 fv=0 cnt=4",
                     misaligned, pc, fetch_valid, instr_count);
        end
        for (int i = 0; i < 4; i++) begin
            npc_op = 2'($urandom); rs_data = $urandom; halt_req = 1'($urandom);
            tick();
        end
        checks++;
        if (misaligned !== 1'b1 || pc !== 32'h3008 || instr_count !== 32'd4 || halted !== 1'b0) begin
            failures++;
            $display("FAIL fault_sticky: m=%b pc=%h cnt=%0d h=%b want m=1 pc=3008 cnt=4 h=0",
                     misaligned, pc, instr_count, halted);
        end
        idle_inputs();
    endtask

    task test_stall();
        do_reset(); tick();
        stall = 1'b1; npc_op = 2'b10; imm26 = 26'h0000C40;
        tick(); tick();
        checks++;
        if (pc !== PC_RST || instr_count !== 32'd0 || fetch_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold: pc=%h cnt=%0d fv=%b want pc=3000 cnt=0 fv=1", pc, instr_count, fetch_valid);
        end
        stall = 1'b0;
        tick();
        npc_op = 2'b00;
        tick();
        checks++;
        if (pc !== 32'h3104 || instr_count !== 32'd2) begin
            failures++;
            $display("FAIL stall_release: pc=%h cnt=%0d want pc=3104 cnt=2", pc, instr_count);
        end
    endtask

    task test_halt();
        do_reset(); tick();
        repeat (6) tick();
        halt_req = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b1 || instr_count !== 32'd7 || pc !== 32'h3018 || fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt: h=%b cnt=%0d pc=%h fv=%b want h=1 cnt=7 pc=3018 fv=0",
                     halted, instr_count, pc, fetch_valid);
        end
        for (int i = 0; i < 4; i++) begin
            npc_op = 2'($urandom); rs_data = $urandom; halt_req = 1'($urandom); stall = 1'($urandom);
            tick();
        end
        checks++;
        if (halted !== 1'b1 || instr_count !== 32'd7 || pc !== 32'h3018 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL halt_sticky: h=%b cnt=%0d pc=%h m=%b want h=1 cnt=7 pc=3018 m=0",
                     halted, instr_count, pc, misaligned);
        end
        idle_inputs();
    endtask

    task test_async_reset();
        // Currently halted at posedge+1; assert reset mid-cycle.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== PC_RST || halted !== 1'b0 || instr_count !== 32'd0 || fetch_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: pc=%h h=%b cnt=%0d fv=%b want pc=3000 h=0 cnt=0 fv=0",
                     pc, halted, instr_count, fetch_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (fetch_valid !== 1'b1 || pc !== PC_RST) begin
            failures++;
            $display("FAIL reboot: fv=%b pc=%h want fv=1 pc=3000", fetch_valid, pc);
        end
    endtask

    task test_halt_masked();
        stall = 1'b1; halt_req = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b0 || fetch_valid !== 1'b1 || pc !== PC_RST || instr_count !== 32'd0) begin
            failures++;
            $display("FAIL halt_masked: h=%b fv=%b pc=%h cnt=%0d want h=0 fv=1 pc=3000 cnt=0",
                     halted, fetch_valid, pc, instr_count);
        end
        idle_inputs();
    endtask

    task test_wrap();
        goto_addr(32'hFFFF_FFFC);
        checks++;
        if (pc_plus4 !== 32'h0 || im_addr !== 10'h3FF) begin
            failures++;
            $display("FAIL wrap_comb: p4=%h ia=%h want p4=0 ia=3ff", pc_plus4, im_addr);
        end
        tick();
        checks++;
        if (pc !== 32'h0 || im_addr !== 10'h000) begin
            failures++;
            $display("FAIL wrap_seq: pc=%h ia=%h want pc=0 ia=0", pc, im_addr);
        end
    endtask

    task test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            stall        = ($urandom_range(0, 3) == 0);
            halt_req     = ($urandom_range(0, 40) == 0);
            npc_op       = 2'($urandom);
            branch_taken = 1'($urandom);
            imm16        = 16'($urandom);
            imm26        = 26'($urandom);
            rs_data      = $urandom;
            if ($urandom_range(0, 7) != 0) rs_data[1:0] = 2'b00;
            model_step();
            tick();
            checks++;
            if (pc !== m_pc || instr_count !== m_cnt || fetch_valid !== (m_st == 1) ||
                halted !== (m_st == 2) || misaligned !== (m_st == 3) ||
                pc_plus4 !== m_pc + 32'd4 || im_addr !== m_pc[11:2]) begin
                failures++;
                $display("FAIL random[%0d]: pc=%h cnt=%0d fv=%b h=%b m=%b p4=%h ia=%h want pc=%h cnt=%0d st=%0d",
                         i, pc, instr_count, fetch_valid, halted, misaligned, pc_plus4, im_addr,
                         m_pc, m_cnt, m_st);
            end
            if ((m_st >= 2 && $urandom_range(0, 2) == 0) || $urandom_range(0, 80) == 0) begin
                do_reset();
            end
        end
        idle_inputs();
    endtask

    initial begin
        m_pc = PC_RST; m_cnt = 32'd0; m_st = 0;
        test_reset();
        test_branch();
        test_jump();
        test_stall();
        test_halt();
        test_async_reset();
        test_halt_masked();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
